hpu_rob_arat_commit: RTL and testbench
======================================

// Module: hpu_rob_arat_commit
// PURPOSE
// In-order retirement tracker between rename/dispatch and the architectural RAT.
// Holds a circular buffer of renamed instructions, gathers out-of-order completions,
// and retires up to PARAL head entries per cycle.
// Retirement drives the ARAT update bus (en/avail/arc_rdst_index/phy_rdst_index; packed
// into update_arat_t by the parent) and releases each retiring entry's previous physical
// register to the free list.
// PARAMETERS
// PARAL   2   lanes per cycle (alloc, complete, retire); equals INST_DEC_PARAL
// DEPTH   16  buffer entries; power of two, >= 2*PARAL
// ARC_W   5   architectural register index width
// PHY_W   6   physical register index width
// IDX_W   $clog2(DEPTH), derived
// PORTS
// clk_i          in   1            clock
// rst_i          in   1            reset, asynchronous, active-low
// alloc_en_i     in   1            allocate group this cycle
// alloc_avail_i  in   PARAL        lane holds an instruction; contiguous from lane 0
// alloc_wr_i     in   PARAL        lane writes a destination register
// alloc_arc_i    in   PARAL*ARC_W  architectural destination per lane
// alloc_phy_i    in   PARAL*PHY_W  new physical destination per lane
// alloc_old_i    in   PARAL*PHY_W  previous mapping of that arc reg per lane
// alloc_rdy_o    out  1            >= PARAL free entries
// alloc_idx_o    out  IDX_W        buffer index given to lane 0 (lane i gets +i, mod DEPTH)
// cmpl_en_i      in   PARAL        completion strobe per lane
// cmpl_idx_i     in   PARAL*IDX_W  buffer index completing
// flush_i        in   1            discard all in-flight entries
// upd_en_o       out  1            ARAT update valid (= |upd_avail_o)
// upd_avail_o    out  PARAL        lane retires with a destination
// upd_arc_o      out  PARAL*ARC_W  arc index to write in ARAT
// upd_phy_o      out  PARAL*PHY_W  phy index to write in ARAT
// free_avail_o   out  PARAL        lane releases free_phy_o
// free_phy_o     out  PARAL*PHY_W  old physical register to free
// cnt_o          out  IDX_W+1      occupied entries
// BEHAVIOUR
// - Reset: head=tail=0, cnt=0, all valid/done bits 0; every output register 0.
//   alloc_rdy_o=1, alloc_idx_o=0.
// - Entry fields: valid, done, wr, arc, phy, old.
// - Alloc: when alloc_en_i && alloc_rdy_o, lane i with avail writes entry tail+i
//   (valid=1, done=0). tail += popcount(avail), mod DEPTH.
// - Non-contiguous avail is illegal (assertion). alloc_en_i while !alloc_rdy_o is ignored.
// - alloc_rdy_o = (DEPTH-cnt) >= PARAL, decoded from registered cnt only.
// - Complete: cmpl_en_i[i] sets done at cmpl_idx_i[i] at the clock edge if that entry is valid.
//   Completions on invalid entries are ignored. Duplicate indices are harmless.
// - Retire scan (combinational on registered state), for k = 0..PARAL-1:
//   entry head+k retires iff valid && done and entries head..head+k-1 all retire.
//   The scan stops at the first not-done entry, so retirement stays strictly in order.
// - Retire effects at the edge:
//   - Each retiring entry has valid cleared. head += n, mod DEPTH.
//   - Output lane k is registered: upd_avail_o[k] = wr; upd_arc_o/upd_phy_o = arc/phy.
//   - free_avail_o[k] = wr; free_phy_o = old.
//   - Non-retiring lanes and lanes with wr=0 drive avail 0 and data 0.
// - Latency: cmpl_en_i at cycle t -> done at edge t -> retired during t+1 -> upd_*/free_* visible in t+2.
//   Outputs are single-cycle pulses.
// - cnt_next = cnt + allocated - retired. Alloc and retire in the same cycle are both applied.
// - Wrap-around: pointers are modulo DEPTH. Full vs empty is distinguished by cnt, never by pointer equality.
// - Flush (highest priority):
//   - At the edge, all valid/done are cleared and head=tail=cnt=0.
//   - Alloc, complete and retire in the flush cycle are discarded; upd_*/free_* are 0 the next cycle.
//   - Outputs already presented during the flush cycle came from the prior cycle's retirement
//     and remain valid. The ARAT applies them on the same edge as its recovery.
// - Reset mid-operation: asynchronous return to the reset state above; no pending output survives.
// TESTING
// - Reset, then alloc 2 lanes (arc 3/4, phy 10/11, old 1/2)
//   -> alloc_idx_o=0, cnt_o=2, upd_en_o=0.
// - Complete idx1 only -> no retire; complete idx0 next cycle
//   -> 2 cycles later upd_avail_o=2'b11, arc 3/4, phy 10/11, free_phy 1/2.
// - Lane0 wr=0, lane1 wr=1, both done -> upd_avail_o=2'b10; head advances by 2; cnt_o drops by 2.
// - Fill to 16 -> alloc_rdy_o=0; extra alloc ignored (cnt stays 16).
//   Retire 2 -> rdy=1; alloc wraps to idx 0.
// - Alloc 4, complete all, assert flush_i in the retire cycle
//   -> next cycle upd_en_o=0, cnt_o=0, alloc_idx_o=0.
// - Simultaneous alloc 2 + retire 2 with cnt 6 -> cnt stays 6; tail/head each advance by 2 mod 16.

Source files
------------

// File: rtl/hpu_rob_arat_commit_if.sv
// Bus bundle for the retirement tracker: dispatch-side alloc/complete/flush inputs,
// plus the retirement outputs (ARAT update and free-list release).
interface hpu_rob_arat_commit_if #(
  parameter int PARAL = 2,
  parameter int DEPTH = 16,
  parameter int ARC_W = 5,
  parameter int PHY_W = 6,
  parameter int IDX_W = $clog2(DEPTH)
);
  logic                   alloc_en_i;
  logic [PARAL-1:0]       alloc_avail_i;
  logic [PARAL-1:0]       alloc_wr_i;
  logic [PARAL*ARC_W-1:0] alloc_arc_i;
  logic [PARAL*PHY_W-1:0] alloc_phy_i;
  logic [PARAL*PHY_W-1:0] alloc_old_i;
  logic                   alloc_rdy_o;
  logic [IDX_W-1:0]       alloc_idx_o;
  logic [PARAL-1:0]       cmpl_en_i;
  logic [PARAL*IDX_W-1:0] cmpl_idx_i;
  logic                   flush_i;
  logic                   upd_en_o;
  logic [PARAL-1:0]       upd_avail_o;
  logic [PARAL*ARC_W-1:0] upd_arc_o;
  logic [PARAL*PHY_W-1:0] upd_phy_o;
  logic [PARAL-1:0]       free_avail_o;
  logic [PARAL*PHY_W-1:0] free_phy_o;
  logic [IDX_W:0]         cnt_o;

  modport slave (
    input  alloc_en_i, alloc_avail_i, alloc_wr_i, alloc_arc_i, alloc_phy_i, alloc_old_i,
    input  cmpl_en_i, cmpl_idx_i, flush_i,
    output alloc_rdy_o, alloc_idx_o, upd_en_o, upd_avail_o, upd_arc_o, upd_phy_o,
    output free_avail_o, free_phy_o, cnt_o
  );

  modport master (
    output alloc_en_i, alloc_avail_i, alloc_wr_i, alloc_arc_i, alloc_phy_i, alloc_old_i,
    output cmpl_en_i, cmpl_idx_i, flush_i,
    input  alloc_rdy_o, alloc_idx_o, upd_en_o, upd_avail_o, upd_arc_o, upd_phy_o,
    input  free_avail_o, free_phy_o, cnt_o
  );
endinterface

// File: rtl/hpu_rob_arat_commit.sv
// In-order retirement tracker: circular buffer of renamed instructions, out-of-order
// completion marking, and up to PARAL in-order retirements per cycle to the ARAT.
module hpu_rob_arat_commit #(
  parameter int PARAL = 2,
  parameter int DEPTH = 16,
  parameter int ARC_W = 5,
  parameter int PHY_W = 6,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  hpu_rob_arat_commit_if.slave bus
);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [PARAL:0] ONE_EXT = 1;

  logic [DEPTH-1:0]       valid_q, valid_d, done_q, done_d;
  logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PARAL-1:0]       upd_avail_q, upd_avail_d, free_avail_q, free_avail_d;
  logic [PARAL*ARC_W-1:0] upd_arc_q, upd_arc_d;
  logic [PARAL*PHY_W-1:0] upd_phy_q, upd_phy_d, free_phy_q, free_phy_d;

  // Entry payload; only meaningful where the matching valid bit is set
  logic [DEPTH-1:0] wr_mem;
  logic [ARC_W-1:0] arc_mem [DEPTH];
  logic [PHY_W-1:0] phy_mem [DEPTH];
  logic [PHY_W-1:0] old_mem [DEPTH];

  logic             alloc_rdy, alloc_fire, chain;
  logic [PARAL-1:0] ret;
  logic [IDX_W-1:0] ret_idx [PARAL];
  logic [IDX_W-1:0] wr_idx [PARAL];
  logic [IDX_W-1:0] cmpl_idx [PARAL];
  logic [CNT_W-1:0] n_ret, n_alloc;
  logic [PARAL:0]   avail_ext;

  assign alloc_rdy  = cnt_q <= CNT_W'(DEPTH - PARAL);
  assign alloc_fire = bus.alloc_en_i && alloc_rdy && !bus.flush_i;
  assign avail_ext  = {1'b0, bus.alloc_avail_i};

  genvar gi;
  generate
    for (gi = 0; gi < PARAL; gi++) begin : g_lane
      assign ret_idx[gi]  = head_q + IDX_W'(gi);
      assign wr_idx[gi]   = tail_q + IDX_W'(gi);
      assign cmpl_idx[gi] = bus.cmpl_idx_i[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Retire scan: a lane retires only if every older lane in the window also retires
  always_comb begin
    chain   = 1'b1;
    ret     = '0;
    n_ret   = '0;
    n_alloc = '0;
    for (int k = 0; k < PARAL; k++) begin
      chain  = chain & valid_q[ret_idx[k]] & done_q[ret_idx[k]];
      ret[k] = chain;
      n_ret  = n_ret + CNT_W'(ret[k]);
      if (alloc_fire) n_alloc = n_alloc + CNT_W'(bus.alloc_avail_i[k]);
    end
  end

  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    upd_avail_d  = '0;
    upd_arc_d    = '0;
    upd_phy_d    = '0;
    free_avail_d = '0;
    free_phy_d   = '0;
    for (int i = 0; i < PARAL; i++)
      if (bus.cmpl_en_i[i] && valid_q[cmpl_idx[i]]) done_d[cmpl_idx[i]] = 1'b1;
    for (int k = 0; k < PARAL; k++) begin
      if (ret[k]) begin
        valid_d[ret_idx[k]] = 1'b0;
        done_d[ret_idx[k]]  = 1'b0;
        if (wr_mem[ret_idx[k]]) begin
          upd_avail_d[k]               = 1'b1;
          upd_arc_d[k*ARC_W +: ARC_W]  = arc_mem[ret_idx[k]];
          upd_phy_d[k*PHY_W +: PHY_W]  = phy_mem[ret_idx[k]];
          free_avail_d[k]              = 1'b1;
          free_phy_d[k*PHY_W +: PHY_W] = old_mem[ret_idx[k]];
        end
      end
    end
    for (int i = 0; i < PARAL; i++)
      if (alloc_fire && bus.alloc_avail_i[i]) begin
        valid_d[wr_idx[i]] = 1'b1;
        done_d[wr_idx[i]]  = 1'b0;
      end
    head_d = head_q + IDX_W'(n_ret);
    tail_d = tail_q + IDX_W'(n_alloc);
    cnt_d  = cnt_q + n_alloc - n_ret;
    if (bus.flush_i) begin
      valid_d      = '0;
      done_d       = '0;
      head_d       = '0;
      tail_d       = '0;
      cnt_d        = '0;
      upd_avail_d  = '0;
      upd_arc_d    = '0;
      upd_phy_d    = '0;
      free_avail_d = '0;
      free_phy_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      upd_avail_q  <= '0;
      upd_arc_q    <= '0;
      upd_phy_q    <= '0;
      free_avail_q <= '0;
      free_phy_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      upd_avail_q  <= upd_avail_d;
      upd_arc_q    <= upd_arc_d;
      upd_phy_q    <= upd_phy_d;
      free_avail_q <= free_avail_d;
      free_phy_q   <= free_phy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < PARAL; i++)
      if (alloc_fire && bus.alloc_avail_i[i]) begin
        wr_mem[wr_idx[i]]  <= bus.alloc_wr_i[i];
        arc_mem[wr_idx[i]] <= bus.alloc_arc_i[i*ARC_W +: ARC_W];
        phy_mem[wr_idx[i]] <= bus.alloc_phy_i[i*PHY_W +: PHY_W];
        old_mem[wr_idx[i]] <= bus.alloc_old_i[i*PHY_W +: PHY_W];
      end
  end

  assign bus.alloc_rdy_o  = alloc_rdy;
  assign bus.alloc_idx_o  = tail_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.upd_en_o     = |upd_avail_q;
  assign bus.upd_avail_o  = upd_avail_q;
  assign bus.upd_arc_o    = upd_arc_q;
  assign bus.upd_phy_o    = upd_phy_q;
  assign bus.free_avail_o = free_avail_q;
  assign bus.free_phy_o   = free_phy_q;

  // Lanes must be packed from lane 0: avail+1 is then a power of two
  a_avail_contig: assert property (@(posedge clk_i) disable iff (!rst_i)
    bus.alloc_en_i |-> (((avail_ext + ONE_EXT) & avail_ext) == '0));
endmodule

// File: tb/tb_hpu_rob_arat_commit.sv
// Scoreboard bench for hpu_rob_arat_commit: directed alloc/complete/flush vectors push
// hand-computed retirement records; a negedge monitor pops and compares them.
module tb_hpu_rob_arat_commit;
  localparam int PARAL = 2;
  localparam int DEPTH = 16;
  localparam int ARC_W = 5;
  localparam int PHY_W = 6;
  localparam int IDX_W = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  hpu_rob_arat_commit_if #(.PARAL(PARAL), .DEPTH(DEPTH), .ARC_W(ARC_W), .PHY_W(PHY_W),
                           .IDX_W(IDX_W)) bus ();

  hpu_rob_arat_commit #(.PARAL(PARAL), .DEPTH(DEPTH), .ARC_W(ARC_W), .PHY_W(PHY_W),
                        .IDX_W(IDX_W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct packed {
    logic [1:0]  av;
    logic [9:0]  arc;
    logic [11:0] phy;
    logic [1:0]  fav;
    logic [11:0] fphy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every presented retirement must match the oldest expected record
  always @(negedge clk_i) begin : monitor
    exp_t act;
    exp_t e;
    if (rst_i === 1'b1 && (bus.upd_en_o || (|bus.free_avail_o))) begin
      act = {bus.upd_avail_o, bus.upd_arc_o, bus.upd_phy_o, bus.free_avail_o, bus.free_phy_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got %h, required no output", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e || bus.upd_en_o !== (|e.av)) begin
          errors++;
          $display("FAIL retire_record: got %h en=%b, required %h", act, bus.upd_en_o, e);
        end else begin
          $display("retire avail=%b arc=%h phy=%h free=%b old=%h", act.av, act.arc, act.phy,
                   act.fav, act.fphy);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [1:0] av, input logic [1:0] wr, input logic [9:0] arc,
                       input logic [11:0] phy, input logic [11:0] old);
    $display("alloc avail=%b wr=%b idx=%0d cnt=%0d", av, wr, bus.alloc_idx_o, bus.cnt_o);
    bus.alloc_en_i    = 1'b1;
    bus.alloc_avail_i = av;
    bus.alloc_wr_i    = wr;
    bus.alloc_arc_i   = arc;
    bus.alloc_phy_i   = phy;
    bus.alloc_old_i   = old;
    cyc();
    bus.alloc_en_i    = 1'b0;
    bus.alloc_avail_i = '0;
    bus.alloc_wr_i    = '0;
  endtask

  task automatic cmpl(input logic [1:0] en, input logic [3:0] i0, input logic [3:0] i1);
    $display("complete en=%b idx0=%0d idx1=%0d", en, i0, i1);
    bus.cmpl_en_i  = en;
    bus.cmpl_idx_i = {i1, i0};
    cyc();
    bus.cmpl_en_i  = '0;
  endtask

  task automatic flush();
    $display("flush");
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
  endtask

  initial begin
    rst_i             = 1'b0;
    bus.alloc_en_i    = 1'b0;
    bus.alloc_avail_i = '0;
    bus.alloc_wr_i    = '0;
    bus.alloc_arc_i   = '0;
    bus.alloc_phy_i   = '0;
    bus.alloc_old_i   = '0;
    bus.cmpl_en_i     = '0;
    bus.cmpl_idx_i    = '0;
    bus.flush_i       = 1'b0;
    #12;
    chk("reset_cnt", bus.cnt_o, 0);
    chk("reset_rdy", bus.alloc_rdy_o, 1);
    chk("reset_idx", bus.alloc_idx_o, 0);
    chk("reset_upd_en", bus.upd_en_o, 0);
    cyc();
    rst_i = 1'b1;

    // Basic alloc, out-of-order completion, in-order retirement
    exp_q.push_back({2'b11, {5'd4, 5'd3}, {6'd11, 6'd10}, 2'b11, {6'd2, 6'd1}});
    alloc(2'b11, 2'b11, {5'd4, 5'd3}, {6'd11, 6'd10}, {6'd2, 6'd1});
    chk("a1_cnt", bus.cnt_o, 2);
    chk("a1_upd_en", bus.upd_en_o, 0);
    chk("a1_idx", bus.alloc_idx_o, 2);
    cmpl(2'b10, 4'd0, 4'd1);
    cyc();
    chk("ooo_no_retire_cnt", bus.cnt_o, 2);
    chk("ooo_no_retire_en", bus.upd_en_o, 0);
    cmpl(2'b01, 4'd0, 4'd0);
    chk("c0_cnt_before", bus.cnt_o, 2);
    cyc();
    chk("c0_cnt_after", bus.cnt_o, 0);
    chk("c0_upd_avail", bus.upd_avail_o, 3);
    cyc();
    chk("pulse_single", bus.upd_en_o, 0);

    // Lane 0 without destination
    chk("wr_idx", bus.alloc_idx_o, 2);
    exp_q.push_back({2'b10, {5'd8, 5'd0}, {6'd21, 6'd0}, 2'b10, {6'd6, 6'd0}});
    alloc(2'b11, 2'b10, {5'd8, 5'd7}, {6'd21, 6'd20}, {6'd6, 6'd5});
    cmpl(2'b11, 4'd2, 4'd3);
    chk("wr_cnt_before", bus.cnt_o, 2);
    cyc();
    chk("wr_cnt_after", bus.cnt_o, 0);
    chk("wr_upd_avail", bus.upd_avail_o, 2);
    cyc();
    chk("wr_head_tail", bus.alloc_idx_o, 4);

    // Fill to DEPTH, overflow attempt, retire two, wrap
    flush();
    chk("fl0_cnt", bus.cnt_o, 0);
    chk("fl0_idx", bus.alloc_idx_o, 0);
    for (int j = 0; j < 8; j++) begin
      alloc(2'b11, 2'b11, {5'(2*j+2), 5'(2*j+1)}, {6'(33+2*j), 6'(32+2*j)},
            {6'(2*j+1), 6'(2*j)});
      if (j == 6) chk("fill14_rdy", bus.alloc_rdy_o, 1);
    end
    chk("full_cnt", bus.cnt_o, 16);
    chk("full_rdy", bus.alloc_rdy_o, 0);
    chk("full_idx", bus.alloc_idx_o, 0);
    alloc(2'b11, 2'b11, {5'd9, 5'd9}, {6'd9, 6'd9}, {6'd9, 6'd9});
    chk("overflow_cnt", bus.cnt_o, 16);
    chk("overflow_idx", bus.alloc_idx_o, 0);
    exp_q.push_back({2'b11, {5'd2, 5'd1}, {6'd33, 6'd32}, 2'b11, {6'd1, 6'd0}});
    cmpl(2'b11, 4'd0, 4'd1);
    chk("full_rdy_still0", bus.alloc_rdy_o, 0);
    cyc();
    chk("drain2_cnt", bus.cnt_o, 14);
    chk("drain2_rdy", bus.alloc_rdy_o, 1);
    chk("wrap_idx", bus.alloc_idx_o, 0);
    alloc(2'b11, 2'b11, {5'd31, 5'd30}, {6'd63, 6'd62}, {6'd61, 6'd60});
    chk("wrap_cnt", bus.cnt_o, 16);
    chk("wrap_idx_after", bus.alloc_idx_o, 2);

    // Flush during a retire cycle discards that retirement
    flush();
    chk("fl1_cnt", bus.cnt_o, 0);
    alloc(2'b11, 2'b11, {5'd10, 5'd9}, {6'd41, 6'd40}, {6'd51, 6'd50});
    alloc(2'b11, 2'b11, {5'd12, 5'd11}, {6'd43, 6'd42}, {6'd53, 6'd52});
    exp_q.push_back({2'b11, {5'd10, 5'd9}, {6'd41, 6'd40}, 2'b11, {6'd51, 6'd50}});
    cmpl(2'b11, 4'd0, 4'd1);
    cmpl(2'b11, 4'd2, 4'd3);
    flush();
    chk("flush_upd_en", bus.upd_en_o, 0);
    chk("flush_free", bus.free_avail_o, 0);
    chk("flush_cnt", bus.cnt_o, 0);
    chk("flush_idx", bus.alloc_idx_o, 0);

    // Simultaneous alloc and retire at cnt 6
    alloc(2'b11, 2'b11, {5'd14, 5'd13}, {6'd45, 6'd44}, {6'd55, 6'd54});
    alloc(2'b11, 2'b11, {5'd16, 5'd15}, {6'd47, 6'd46}, {6'd57, 6'd56});
    alloc(2'b11, 2'b11, {5'd18, 5'd17}, {6'd49, 6'd48}, {6'd59, 6'd58});
    chk("six_cnt", bus.cnt_o, 6);
    exp_q.push_back({2'b11, {5'd14, 5'd13}, {6'd45, 6'd44}, 2'b11, {6'd55, 6'd54}});
    cmpl(2'b11, 4'd0, 4'd1);
    alloc(2'b11, 2'b11, {5'd20, 5'd19}, {6'd39, 6'd38}, {6'd37, 6'd36});
    chk("simul_cnt", bus.cnt_o, 6);
    chk("simul_idx", bus.alloc_idx_o, 8);
    exp_q.push_back({2'b11, {5'd16, 5'd15}, {6'd47, 6'd46}, 2'b11, {6'd57, 6'd56}});
    cmpl(2'b11, 4'd2, 4'd3);
    cyc();
    chk("head2_cnt", bus.cnt_o, 4);

    // Asynchronous reset while a retirement is pending
    cmpl(2'b11, 4'd4, 4'd5);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_cnt", bus.cnt_o, 0);
    chk("arst_rdy", bus.alloc_rdy_o, 1);
    chk("arst_idx", bus.alloc_idx_o, 0);
    chk("arst_upd_en", bus.upd_en_o, 0);
    cyc();
    cyc();
    rst_i = 1'b1;
    cyc();
    cyc();
    chk("arst_no_output", bus.upd_en_o, 0);
    chk("arst_cnt_after", bus.cnt_o, 0);

    cyc();
    cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
